mmio_port_bank: RTL and testbench

//  Parametrised memory-mapped I/O port bank on the 4510 CPU bus; successor to the single 8-bit port at 16'hBFFC.

---
 rtl/mmio_port_bank_if.sv | 22 ++
 rtl/mmio_port_bank.sv | 105 ++++++++++
 tb/tb_mmio_port_bank.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_port_bank_if.sv
// CPU-side bus bundle for mmio_port_bank: next-cycle address/write strobe in, registered read data and select out.
interface mmio_port_bank_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic              ready;
   logic [ADDR_W-1:0] address_next;
   logic              write_next;
   logic [DATA_W-1:0] data_i;
   logic [DATA_W-1:0] data_o;
   logic              cs;

   modport master (
      output ready, address_next, write_next, data_i,
      input  data_o, cs
   );

   modport slave (
      input  ready, address_next, write_next, data_i,
      output data_o, cs
   );
endinterface

// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of R/W output ports, a countdown timer with sticky flag, and CPU irq/nmi lines.
// PORT0 lives at BASE_ADDR so legacy programs poking the old single port keep working.
module mmio_port_bank #(
   parameter int unsigned     ADDR_W    = 16,
   parameter int unsigned     DATA_W    = 8,
   parameter int unsigned     NUM_PORTS = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hBFFC
) (
   input  logic                        clk,
   input  logic                        reset,
   mmio_port_bank_if.slave             bus,
   output logic [NUM_PORTS*DATA_W-1:0] port_out,
   output logic                        irq,
   output logic                        nmi
);

   localparam logic [ADDR_W-1:0] TIMER_OFF  = ADDR_W'(NUM_PORTS);
   localparam logic [ADDR_W-1:0] STATUS_OFF = ADDR_W'(NUM_PORTS + 1);
   localparam logic [ADDR_W-1:0] NUM_REGS   = ADDR_W'(NUM_PORTS + 2);

   logic [DATA_W-1:0] port_q [NUM_PORTS];
   logic [DATA_W-1:0] port_d [NUM_PORTS];
   logic [DATA_W-1:0] count_q, count_d;
   logic              flag_q, flag_d;
   logic              ien_q, ien_d;
   logic [DATA_W-1:0] data_q;
   logic              cs_q;
   logic [DATA_W-1:0] rd_val;
   logic [ADDR_W-1:0] offset;
   logic              hit;
   logic              wr;
   logic              expire;

   // Address decode: offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR miss.
   always_comb begin
      offset = bus.address_next - BASE_ADDR;
      hit    = (offset < NUM_REGS);
      wr     = bus.write_next & bus.ready & hit;
   end

   always_comb begin
      rd_val = '0;
      for (int n = 0; n < int'(NUM_PORTS); n++) begin
         if (offset == ADDR_W'(n)) rd_val = port_q[n];
      end
      if (offset == TIMER_OFF)  rd_val = count_q;
      if (offset == STATUS_OFF) rd_val = DATA_W'({ien_q, flag_q});
   end

   // Next state; a TIMER write overrides the decrement, and expiry beats a FLAG clear.
   always_comb begin
      port_d  = port_q;
      count_d = count_q;
      flag_d  = flag_q;
      ien_d   = ien_q;
      expire  = 1'b0;
      for (int n = 0; n < int'(NUM_PORTS); n++) begin
         if (wr && (offset == ADDR_W'(n))) port_d[n] = bus.data_i;
      end
      if (bus.ready && (count_q != '0)) begin
         count_d = count_q - DATA_W'(1);
         expire  = (count_q == DATA_W'(1));
      end
      if (wr && (offset == TIMER_OFF)) begin
         count_d = bus.data_i;
         expire  = 1'b0;
      end
      if (wr && (offset == STATUS_OFF)) begin
         ien_d = bus.data_i[1];
         if (bus.data_i[0]) flag_d = 1'b0;
      end
      if (expire) flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < int'(NUM_PORTS); n++) port_q[n] <= '0;
         count_q <= '0;
         flag_q  <= 1'b0;
         ien_q   <= 1'b0;
         data_q  <= '0;
         cs_q    <= 1'b0;
      end else begin
         port_q  <= port_d;
         count_q <= count_d;
         flag_q  <= flag_d;
         ien_q   <= ien_d;
         if (bus.ready && hit) data_q <= rd_val;
         if (bus.ready)        cs_q   <= hit;
      end
   end

   always_comb begin
      port_out = '0;
      for (int n = 0; n < int'(NUM_PORTS); n++) begin
         port_out[n*DATA_W +: DATA_W] = port_q[n];
      end
   end

   assign bus.data_o = data_q;
   assign bus.cs     = cs_q;
   assign irq        = port_q[0][0] | (flag_q & ien_q);
   assign nmi        = port_q[0][1];

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed self-checking bench for mmio_port_bank with the default 4-port map at 16'hBFFC.
module tb_mmio_port_bank;

   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned NUM_PORTS = 4;

   localparam logic [15:0] A_P0     = 16'hBFFC;
   localparam logic [15:0] A_P1     = 16'hBFFD;
   localparam logic [15:0] A_P2     = 16'hBFFE;
   localparam logic [15:0] A_TIMER  = 16'hC000;
   localparam logic [15:0] A_STATUS = 16'hC001;
   localparam logic [15:0] A_ABOVE  = 16'hC002;
   localparam logic [15:0] A_BELOW  = 16'hBFFB;
   localparam logic [15:0] A_IDLE   = 16'h0000;

   logic clk = 1'b0;
   logic reset;
   logic [NUM_PORTS*DATA_W-1:0] port_out;
   logic irq, nmi;
   int   checks   = 0;
   int   failures = 0;

   mmio_port_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mmio_port_bank #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .BASE_ADDR(16'hBFFC)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .port_out(port_out), .irq(irq), .nmi(nmi)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ready        = 1'b1;
      bus.write_next   = 1'b0;
      bus.address_next = A_IDLE;
      bus.data_i       = 8'h00;
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
      bus.ready        = 1'b1;
      bus.write_next   = 1'b1;
      bus.address_next = a;
      bus.data_i       = d;
      tick();
      idle();
   endtask

   task automatic rd_reg(input logic [15:0] a);
      bus.ready        = 1'b1;
      bus.write_next   = 1'b0;
      bus.address_next = a;
      tick();
      idle();
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      bus.ready        = 1'b1;
      bus.write_next   = 1'b1;
      bus.address_next = A_P0;
      bus.data_i       = 8'hFF;
      tick();
      tick();
      checks++; if (port_out !== 32'h0) begin failures++; $display("FAIL reset_port_out: got %h want %h", port_out, 32'h0); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
      checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL reset_nmi: got %b want 0", nmi); end
      checks++; if (bus.data_o !== 8'h00) begin failures++; $display("FAIL reset_data_o: got %h want 00", bus.data_o); end
      checks++; if (bus.cs !== 1'b0) begin failures++; $display("FAIL reset_cs: got %b want 0", bus.cs); end
      reset = 1'b0;
      idle();
      tick();
   endtask

   task automatic test_legacy();
      wr_reg(A_P0, 8'h01);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL legacy_irq_set: got %b want 1", irq); end
      checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL legacy_nmi_low: got %b want 0", nmi); end
      wr_reg(A_P0, 8'h02);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL legacy_irq_clr: got %b want 0", irq); end
      checks++; if (nmi !== 1'b1) begin failures++; $display("FAIL legacy_nmi_set: got %b want 1", nmi); end
      rd_reg(A_P0);
      checks++; if (bus.data_o !== 8'h02) begin failures++; $display("FAIL legacy_read: got %h want 02", bus.data_o); end
      checks++; if (bus.cs !== 1'b1) begin failures++; $display("FAIL legacy_cs: got %b want 1", bus.cs); end
      checks++; if (port_out !== 32'h0000_0002) begin failures++; $display("FAIL legacy_port_out: got %h want 00000002", port_out); end
   endtask

   task automatic test_timer();
      wr_reg(A_STATUS, 8'h02);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL timer_ien_only: got %b want 0", irq); end
      wr_reg(A_TIMER, 8'd5);
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (irq !== 1'b0) begin failures++; $display("FAIL timer_early_%0d: got %b want 0", i, irq); end
      end
      tick();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL timer_expire: got %b want 1", irq); end
      wr_reg(A_STATUS, 8'h01);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL timer_w1c: got %b want 0", irq); end
      rd_reg(A_TIMER);
      checks++; if (bus.data_o !== 8'h00) begin failures++; $display("FAIL timer_stays_zero: got %h want 00", bus.data_o); end
      rd_reg(A_STATUS);
      checks++; if (bus.data_o !== 8'h00) begin failures++; $display("FAIL timer_status: got %h want 00", bus.data_o); end
      wr_reg(A_STATUS, 8'h02);
   endtask

   task automatic test_ready_stall();
      wr_reg(A_TIMER, 8'd3);
      bus.ready = 1'b0; bus.write_next = 1'b1; bus.address_next = A_P2; bus.data_i = 8'hAA;
      tick();
      tick();
      bus.ready = 1'b1; bus.write_next = 1'b0; bus.address_next = A_P0;
      tick();
      checks++; if (bus.data_o !== 8'h02) begin failures++; $display("FAIL stall_read_p0: got %h want 02", bus.data_o); end
      bus.address_next = A_IDLE;
      tick();
      bus.ready = 1'b0; bus.write_next = 1'b1; bus.address_next = A_P2; bus.data_i = 8'hAA;
      tick();
      checks++; if (bus.data_o !== 8'h02) begin failures++; $display("FAIL stall_data_hold: got %h want 02", bus.data_o); end
      tick();
      checks++; if (bus.cs !== 1'b0) begin failures++; $display("FAIL stall_cs_hold: got %b want 0", bus.cs); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL stall_early: got %b want 0", irq); end
      bus.ready = 1'b1; bus.write_next = 1'b0; bus.address_next = A_P0;
      tick();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL stall_expire: got %b want 1", irq); end
      checks++; if (port_out[23:16] !== 8'h00) begin failures++; $display("FAIL stall_write_ignored: got %h want 00", port_out[23:16]); end
      idle();
      wr_reg(A_STATUS, 8'h03);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL stall_clear: got %b want 0", irq); end
   endtask

   task automatic test_collisions();
      wr_reg(A_TIMER, 8'd2);
      tick();
      wr_reg(A_STATUS, 8'h03);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL coll_set_wins: got %b want 1", irq); end
      rd_reg(A_STATUS);
      checks++; if (bus.data_o !== 8'h03) begin failures++; $display("FAIL coll_status: got %h want 03", bus.data_o); end
      wr_reg(A_STATUS, 8'h03);
      wr_reg(A_TIMER, 8'd5);
      tick();
      wr_reg(A_TIMER, 8'd9);
      rd_reg(A_TIMER);
      checks++; if (bus.data_o !== 8'd9) begin failures++; $display("FAIL coll_timer_write_wins: got %h want 09", bus.data_o); end
      wr_reg(A_TIMER, 8'd0);
      tick();
      tick();
      rd_reg(A_TIMER);
      checks++; if (bus.data_o !== 8'd0) begin failures++; $display("FAIL coll_timer_stop: got %h want 00", bus.data_o); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL coll_stop_no_flag: got %b want 0", irq); end
      wr_reg(A_P1, 8'h11);
      wr_reg(A_P1, 8'h22);
      checks++; if (bus.data_o !== 8'h11) begin failures++; $display("FAIL coll_rw_old: got %h want 11", bus.data_o); end
      checks++; if (port_out[15:8] !== 8'h22) begin failures++; $display("FAIL coll_rw_new: got %h want 22", port_out[15:8]); end
   endtask

   task automatic test_decode();
      wr_reg(A_ABOVE, 8'hFF);
      checks++; if (bus.cs !== 1'b0) begin failures++; $display("FAIL decode_above_cs: got %b want 0", bus.cs); end
      checks++; if (bus.data_o !== 8'h11) begin failures++; $display("FAIL decode_above_hold: got %h want 11", bus.data_o); end
      checks++; if (port_out !== 32'h0000_2202) begin failures++; $display("FAIL decode_above_ports: got %h want 00002202", port_out); end
      wr_reg(A_BELOW, 8'hFF);
      checks++; if (bus.cs !== 1'b0) begin failures++; $display("FAIL decode_below_cs: got %b want 0", bus.cs); end
      checks++; if (port_out !== 32'h0000_2202) begin failures++; $display("FAIL decode_below_ports: got %h want 00002202", port_out); end
      checks++; if ({irq, nmi} !== 2'b01) begin failures++; $display("FAIL decode_irq_nmi: got %b want 01", {irq, nmi}); end
      rd_reg(A_STATUS);
      checks++; if (bus.data_o !== 8'h02) begin failures++; $display("FAIL decode_status: got %h want 02", bus.data_o); end
   endtask

   task automatic test_reset_mid_count();
      wr_reg(A_TIMER, 8'd3);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (port_out !== 32'h0) begin failures++; $display("FAIL rmid_ports: got %h want 0", port_out); end
      checks++; if (bus.data_o !== 8'h00) begin failures++; $display("FAIL rmid_data_o: got %h want 00", bus.data_o); end
      wr_reg(A_STATUS, 8'h02);
      for (int i = 0; i < 4; i++) tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rmid_no_flag: got %b want 0", irq); end
      rd_reg(A_TIMER);
      checks++; if (bus.data_o !== 8'h00) begin failures++; $display("FAIL rmid_count: got %h want 00", bus.data_o); end
      rd_reg(A_STATUS);
      checks++; if (bus.data_o !== 8'h02) begin failures++; $display("FAIL rmid_status: got %h want 02", bus.data_o); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_legacy();
      test_timer();
      test_ready_stall();
      test_collisions();
      test_decode();
      test_reset_mid_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
